dcache_refill_unit: RTL and testbench
=====================================

Name: dcache_refill_unit

Overview:
- Miss-side writer for the data-cache register array.
- Accepts one miss address from the load/store pipeline and issues a block-aligned read to memory.
- Collects 2^double_word_offset_width 64-bit beats into a block buffer, then drives a single-cycle block write (data, tag, line index) into the cache registers.
- Snoops committed stores during the refill and merges them into the buffer, so the refill write never erases a committed store.

Parameters:
- double_word_offset_width, 3, log2 of double words per block (block_size = 8).
- line_width, 6, log2 of cache lines (cache_depth = 64).
- tag_width (localparam), 32-3-double_word_offset_width-line_width = 20, tag bits.

Ports:
- clock  input  1  clock
- reset  input  1  synchronous active-high reset
- miss_valid  input  1  pipeline miss request
- miss_address  input  32  byte address of missing access
- miss_ready  output  1  unit idle; miss accepted when valid&ready
- mem_req_valid  output  1  memory read request
- mem_req_address  output  32  block-aligned address (low 3+double_word_offset_width bits zero)
- mem_req_ready  input  1  memory accepts request
- mem_resp_valid  input  1  one 64-bit beat valid, ascending dword order from offset 0
- mem_resp_data  input  64  beat data
- commit_store  input  1  store committed this cycle
- store_address  input  32  store byte address
- store_data  input  64  full double word stored
- write_in  output  1  block write strobe to cache registers
- write_line_index  output  line_width  line being filled
- write_block  output  64*block_size  dword j at bits [64j+63:64j]
- write_tag  output  tag_width  tag of filled line
- refill_done  output  1  pulse, coincident with write_in

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- States: IDLE, REQ, COLLECT, WRITE. Reset forces IDLE from any state.
- Reset clears beat counter and merge mask; buffer content is don't-care.
- Reset values: miss_ready=1, mem_req_valid=0, write_in=0, refill_done=0. mem_req_address, write_line_index and write_tag are 0.
- Reset mid-refill discards all collected beats and merges; no write_in occurs. Memory is reset by the same reset, so no stale beats arrive.
- IDLE:
  - miss_ready=1.
  - On miss_valid, latch the block address = miss_address with bits [3+double_word_offset_width-1:0] cleared; clear merge mask and beat counter; go to REQ.
- REQ:
  - mem_req_valid=1 and mem_req_address stay stable until mem_req_ready.
  - On the handshake cycle go to COLLECT. Beats are only accepted in COLLECT.
- COLLECT:
  - Each mem_resp_valid writes buffer[beat_count], unless mask[beat_count] is set, then increments beat_count.
  - The beat at beat_count = block_size-1 moves the FSM to WRITE. The counter wraps to 0.
  - mem_resp_valid outside COLLECT is a protocol error and is ignored.
- WRITE (exactly one cycle):
  - write_in=1 and refill_done=1; then go to IDLE, where miss_ready=1 on the next cycle.
  - Minimum miss-accept to write_in latency: 2 + block_size cycles (REQ ready immediately, back-to-back beats).
- Store merge, in REQ, COLLECT and WRITE:
  - Applies when commit_store is set and store_address[31:3+double_word_offset_width] equals the latched block address.
  - Write store_data to buffer[store_address[3+double_word_offset_width-1:3]] and set that mask bit.
  - A store and a response beat to the same dword in the same cycle: the store wins.
  - In WRITE, the merge is combinational into write_block, because the cache registers drop commit_store while write_in is high.
  - Non-matching stores are ignored.
  - Stores in IDLE are ignored; the cache registers handle them directly.
- Derived outputs: write_line_index = block_address[line_width+3+double_word_offset_width-1:3+double_word_offset_width]; write_tag = block_address[31:32-tag_width]. Both are held from acceptance until the next miss.
- A new miss arriving during WRITE is not accepted until IDLE.

Decomposition:
- Shared package dcache_pkg:
  - Constants DWORD_OFFSET_WIDTH, LINE_WIDTH, TAG_WIDTH, BLOCK_SIZE.
  - Refill state enum.
  - Address field-extract functions (tag, line, dword index, block align), also used by the cache registers and the hit logic.
- One sub-module, dcache_refill_buffer: block_size x 64 registers plus merge mask, with beat write, store write (priority) and combinational merged block output.

Test Plan:
- Basic refill:
  - Stimulus: miss 0x0000_1238, mem_req_ready=1, beats 0..7 = 0x100+i back-to-back.
  - Response: mem_req_address 0x0000_1200, write_in at cycle 10 after accept, line 0x08, tag 0x00001, dword i = 0x100+i.
- Backpressure and gaps:
  - Stimulus: mem_req_ready low 3 cycles, then beats with bubbles.
  - Response: request held stable, write_in once after 8th beat, no early write.
- Store before beat:
  - Stimulus: during COLLECT after 2 beats, store 0xDEAD to 0x1228.
  - Response: dword 5 = 0xDEAD, not the memory beat.
- Same-cycle collision and WRITE-cycle store:
  - Stimulus: store to dword 3 while beat 3 arrives; store to dword 7 in the WRITE cycle.
  - Response: both store values appear in write_block.
- Non-matching store:
  - Stimulus: store to 0x0000_2238.
  - Response: block unchanged.
- Reset mid-COLLECT after 4 beats:
  - Response: next cycle IDLE, miss_ready=1, no write_in. A subsequent miss refills fully and correctly.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache constants, refill state encoding and address field helpers.
// The cache registers and hit logic slice addresses with the same helpers.
package dcache_pkg;

   localparam int DWORD_OFFSET_WIDTH = 3;
   localparam int LINE_WIDTH         = 6;
   localparam int BLOCK_OFFSET_WIDTH = 3 + DWORD_OFFSET_WIDTH;
   localparam int TAG_WIDTH          = 32 - BLOCK_OFFSET_WIDTH - LINE_WIDTH;
   localparam int BLOCK_SIZE         = 1 << DWORD_OFFSET_WIDTH;

   typedef enum logic [1:0] {
      REFILL_IDLE,
      REFILL_REQ,
      REFILL_COLLECT,
      REFILL_WRITE
   } refill_state_t;

   function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [31:0] addr);
      return addr[31:32-TAG_WIDTH];
   endfunction

   function automatic logic [LINE_WIDTH-1:0] addr_line(input logic [31:0] addr);
      return addr[LINE_WIDTH+BLOCK_OFFSET_WIDTH-1:BLOCK_OFFSET_WIDTH];
   endfunction

   function automatic logic [DWORD_OFFSET_WIDTH-1:0] addr_dword(input logic [31:0] addr);
      return addr[BLOCK_OFFSET_WIDTH-1:3];
   endfunction

   function automatic logic [31:0] block_align(input logic [31:0] addr);
      return {addr[31:BLOCK_OFFSET_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_refill_buffer.sv
// Refill block buffer: one 64-bit register per dword plus a merge mask that marks
// dwords already overwritten by committed stores, so late memory beats cannot undo them.
module dcache_refill_buffer #(
   parameter  int IDX_W = 3,
   localparam int DEPTH = 1 << IDX_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  beat_we,
   input  logic [IDX_W-1:0]      beat_idx,
   input  logic [63:0]           beat_data,
   input  logic                  store_we,
   input  logic [IDX_W-1:0]      store_idx,
   input  logic [63:0]           store_data,
   output logic [64*DEPTH-1:0]   merged_block
);

   logic [DEPTH-1:0][63:0] data_q, data_d;
   logic [DEPTH-1:0]       mask_q, mask_d;

   always_comb begin
      data_d       = data_q;
      mask_d       = clear ? '0 : mask_q;
      merged_block = data_q;
      for (int j = 0; j < DEPTH; j++) begin
         if (beat_we && beat_idx == IDX_W'(j) && !mask_q[j])
            data_d[j] = beat_data;
         // A store to the same dword as a beat overrides it; it also bypasses
         // into the output so the write cycle sees it without a register delay.
         if (store_we && store_idx == IDX_W'(j)) begin
            data_d[j]               = store_data;
            mask_d[j]               = 1'b1;
            merged_block[64*j +: 64] = store_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
   end

   always_ff @(posedge clock) begin
      data_q <= data_d;
   end

endmodule

// File: rtl/dcache_refill_unit.sv
// Data-cache miss refill: requests a block from memory, collects its beats while
// merging committed stores, then writes the whole line into the cache registers.
module dcache_refill_unit
   import dcache_pkg::*;
#(
   parameter  int double_word_offset_width = DWORD_OFFSET_WIDTH,
   parameter  int line_width               = LINE_WIDTH,
   localparam int block_size               = 1 << double_word_offset_width,
   localparam int boff                     = 3 + double_word_offset_width,
   localparam int tag_width                = 32 - boff - line_width
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        miss_valid,
   input  logic [31:0]                 miss_address,
   output logic                        miss_ready,
   output logic                        mem_req_valid,
   output logic [31:0]                 mem_req_address,
   input  logic                        mem_req_ready,
   input  logic                        mem_resp_valid,
   input  logic [63:0]                 mem_resp_data,
   input  logic                        commit_store,
   input  logic [31:0]                 store_address,
   input  logic [63:0]                 store_data,
   output logic                        write_in,
   output logic [line_width-1:0]       write_line_index,
   output logic [64*block_size-1:0]    write_block,
   output logic [tag_width-1:0]        write_tag,
   output logic                        refill_done
);

   refill_state_t                        state_q, state_d;
   logic [31:0]                          block_addr_q, block_addr_d;
   logic [double_word_offset_width-1:0]  beat_cnt_q, beat_cnt_d;
   logic miss_ready_q, miss_ready_d;
   logic mem_req_valid_q, mem_req_valid_d;
   logic write_in_q, write_in_d;
   logic refill_done_q, refill_done_d;
   logic buf_clear, beat_we, store_we, store_hit;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{store_address[2:0], miss_address[boff-1:0]};
   assign store_hit        = store_address[31:boff] == block_addr_q[31:boff];

   always_comb begin
      state_d         = state_q;
      block_addr_d    = block_addr_q;
      beat_cnt_d      = beat_cnt_q;
      miss_ready_d    = miss_ready_q;
      mem_req_valid_d = mem_req_valid_q;
      write_in_d      = 1'b0;
      refill_done_d   = 1'b0;
      buf_clear       = 1'b0;
      beat_we         = 1'b0;
      store_we        = commit_store && store_hit && state_q != REFILL_IDLE;
      case (state_q)
         REFILL_IDLE: begin
            miss_ready_d = 1'b1;
            if (miss_valid) begin
               block_addr_d    = {miss_address[31:boff], {boff{1'b0}}};
               beat_cnt_d      = '0;
               buf_clear       = 1'b1;
               miss_ready_d    = 1'b0;
               mem_req_valid_d = 1'b1;
               state_d         = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               state_d         = REFILL_COLLECT;
            end
         end
         REFILL_COLLECT: begin
            if (mem_resp_valid) begin
               beat_we    = 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (&beat_cnt_q) begin
                  write_in_d    = 1'b1;
                  refill_done_d = 1'b1;
                  state_d       = REFILL_WRITE;
               end
            end
         end
         REFILL_WRITE: begin
            miss_ready_d = 1'b1;
            state_d      = REFILL_IDLE;
         end
         default: state_d = REFILL_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= REFILL_IDLE;
         block_addr_q    <= '0;
         beat_cnt_q      <= '0;
         miss_ready_q    <= 1'b1;
         mem_req_valid_q <= 1'b0;
         write_in_q      <= 1'b0;
         refill_done_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         block_addr_q    <= block_addr_d;
         beat_cnt_q      <= beat_cnt_d;
         miss_ready_q    <= miss_ready_d;
         mem_req_valid_q <= mem_req_valid_d;
         write_in_q      <= write_in_d;
         refill_done_q   <= refill_done_d;
      end
   end

   dcache_refill_buffer #(.IDX_W(double_word_offset_width)) u_buffer (
      .clock        (clock),
      .reset        (reset),
      .clear        (buf_clear),
      .beat_we      (beat_we),
      .beat_idx     (beat_cnt_q),
      .beat_data    (mem_resp_data),
      .store_we     (store_we),
      .store_idx    (store_address[boff-1:3]),
      .store_data   (store_data),
      .merged_block (write_block)
   );

   assign miss_ready       = miss_ready_q;
   assign mem_req_valid    = mem_req_valid_q;
   assign mem_req_address  = block_addr_q;
   assign write_in         = write_in_q;
   assign refill_done      = refill_done_q;
   assign write_line_index = block_addr_q[line_width+boff-1:boff];
   assign write_tag        = block_addr_q[31:32-tag_width];

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Scoreboard bench for the refill unit: expected requests and line writes are queued
// by the stimulus, and a negedge monitor checks them when the DUT presents them.
module tb_dcache_refill_unit;

   logic         clock = 1'b0;
   logic         reset;
   logic         miss_valid;
   logic [31:0]  miss_address;
   logic         miss_ready;
   logic         mem_req_valid;
   logic [31:0]  mem_req_address;
   logic         mem_req_ready;
   logic         mem_resp_valid;
   logic [63:0]  mem_resp_data;
   logic         commit_store;
   logic [31:0]  store_address;
   logic [63:0]  store_data;
   logic         write_in;
   logic [5:0]   write_line_index;
   logic [511:0] write_block;
   logic [19:0]  write_tag;
   logic         refill_done;

   dcache_refill_unit dut (
      .clock            (clock),
      .reset            (reset),
      .miss_valid       (miss_valid),
      .miss_address     (miss_address),
      .miss_ready       (miss_ready),
      .mem_req_valid    (mem_req_valid),
      .mem_req_address  (mem_req_address),
      .mem_req_ready    (mem_req_ready),
      .mem_resp_valid   (mem_resp_valid),
      .mem_resp_data    (mem_resp_data),
      .commit_store     (commit_store),
      .store_address    (store_address),
      .store_data       (store_data),
      .write_in         (write_in),
      .write_line_index (write_line_index),
      .write_block      (write_block),
      .write_tag        (write_tag),
      .refill_done      (refill_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]   line;
      logic [19:0]  tag;
      logic [511:0] blk;
      int           lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] req_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int writes = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset === 1'b0) begin
         if (mem_req_valid) begin
            if (req_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_mem_req: got %0h expected none", mem_req_address);
            end else begin
               chk("mem_req_address", mem_req_address, req_q[0]);
               if (mem_req_ready) void'(req_q.pop_front());
            end
         end
         if (write_in) begin
            writes++;
            chk("refill_done", refill_done, 1);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got line %0h expected none", write_line_index);
            end else begin
               e = exp_q.pop_front();
               chk("write_line_index", write_line_index, e.line);
               chk("write_tag", write_tag, e.tag);
               chk("write_block", write_block, e.blk);
               if (e.lat != 0) chk("write_latency", cyc + 1 - accept_cyc, e.lat);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit bv, input logic [63:0] bd,
                        input bit sv, input logic [31:0] sa, input logic [63:0] sd);
      mem_resp_valid = bv;
      mem_resp_data  = bd;
      commit_store   = sv;
      store_address  = sa;
      store_data     = sd;
      tick();
      mem_resp_valid = 1'b0;
      commit_store   = 1'b0;
   endtask

   task automatic beat(input logic [63:0] d);
      drive(1'b1, d, 1'b0, 32'h0, 64'h0);
   endtask

   task automatic start_miss(input logic [31:0] a, input bit expect_write,
                             input logic [5:0] line, input logic [19:0] tag,
                             input logic [511:0] blk, input int lat);
      int n = 0;
      exp_t e;
      req_q.push_back({a[31:6], 6'h0});
      if (expect_write) begin
         e.line = line; e.tag = tag; e.blk = blk; e.lat = lat;
         exp_q.push_back(e);
      end
      miss_valid   = 1'b1;
      miss_address = a;
      while (!miss_ready && n < 20) begin tick(); n++; end
      if (!miss_ready) begin
         checks++; errors++;
         $display("FAIL miss_accept_timeout: got miss_ready=0 expected 1");
      end
      tick();
      accept_cyc = cyc;
      miss_valid = 1'b0;
   endtask

   task automatic serve_req(input int delay);
      int n = 0;
      while (!mem_req_valid && n < 20) begin tick(); n++; end
      if (!mem_req_valid) begin
         checks++; errors++;
         $display("FAIL mem_req_timeout: got mem_req_valid=0 expected 1");
      end
      repeat (delay) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
   endtask

   function automatic logic [511:0] base_blk(input logic [63:0] b);
      logic [511:0] r;
      for (int i = 0; i < 8; i++) r[64*i +: 64] = b + 64'(i);
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [511:0] blk;
      int w0;
      reset = 1'b1; miss_valid = 1'b0; miss_address = '0; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_data = '0; commit_store = 1'b0;
      store_address = '0; store_data = '0;
      tick(); tick();
      chk("rst_miss_ready", miss_ready, 1);
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_write_in", write_in, 0);
      chk("rst_refill_done", refill_done, 0);
      chk("rst_mem_req_address", mem_req_address, 0);
      chk("rst_line", write_line_index, 0);
      chk("rst_tag", write_tag, 0);
      reset = 1'b0;
      tick();

      // basic refill, minimum latency
      start_miss(32'h0000_1238, 1'b1, 6'h08, 20'h00001, base_blk(64'h100), 10);
      serve_req(0);
      for (int i = 0; i < 8; i++) beat(64'h100 + 64'(i));
      tick();
      chk("idle_miss_ready", miss_ready, 1);

      // backpressure, store during REQ, beats with bubbles
      blk = base_blk(64'h200);
      blk[63:0] = 64'hC0DE;
      w0 = writes;
      start_miss(32'h0000_4A10, 1'b1, 6'h28, 20'h00004, blk, 0);
      drive(1'b0, 64'h0, 1'b1, 32'h0000_4A00, 64'hC0DE);
      tick(); tick();
      serve_req(0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("no_early_write", writes, w0);
         beat(64'h200 + 64'(i));
         if (i == 1 || i == 3 || i == 6) tick();
      end
      tick();
      chk("single_write", writes, w0 + 1);

      // store to a dword before its beat arrives
      blk = base_blk(64'h300);
      blk[5*64 +: 64] = 64'hDEAD;
      start_miss(32'h0000_1200, 1'b1, 6'h08, 20'h00001, blk, 0);
      serve_req(0);
      beat(64'h300); beat(64'h301);
      drive(1'b0, 64'h0, 1'b1, 32'h0000_1228, 64'hDEAD);
      for (int i = 2; i < 8; i++) beat(64'h300 + 64'(i));
      tick();

      // same-cycle store/beat collision, then a store in the WRITE cycle
      blk = base_blk(64'h400);
      blk[3*64 +: 64] = 64'hAAAA_0003;
      blk[7*64 +: 64] = 64'hBBBB_0007;
      start_miss(32'h0003_0040, 1'b1, 6'h01, 20'h00030, blk, 0);
      serve_req(0);
      for (int i = 0; i < 3; i++) beat(64'h400 + 64'(i));
      drive(1'b1, 64'h403, 1'b1, 32'h0003_0058, 64'hAAAA_0003);
      for (int i = 4; i < 8; i++) beat(64'h400 + 64'(i));
      drive(1'b0, 64'h0, 1'b1, 32'h0003_0078, 64'hBBBB_0007);

      // non-matching store leaves the block untouched
      start_miss(32'h0000_1200, 1'b1, 6'h08, 20'h00001, base_blk(64'h500), 0);
      serve_req(0);
      for (int i = 0; i < 4; i++) beat(64'h500 + 64'(i));
      drive(1'b0, 64'h0, 1'b1, 32'h0000_2238, 64'hBAD);
      for (int i = 4; i < 8; i++) beat(64'h500 + 64'(i));
      tick();

      // reset in the middle of COLLECT, then a clean refill
      w0 = writes;
      start_miss(32'h0000_1200, 1'b0, 6'h0, 20'h0, '0, 0);
      serve_req(0);
      for (int i = 0; i < 4; i++) beat(64'h600 + 64'(i));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_miss_ready", miss_ready, 1);
      chk("midrst_mem_req_valid", mem_req_valid, 0);
      chk("midrst_write_in", write_in, 0);
      repeat (6) tick();
      chk("midrst_no_write", writes, w0);
      start_miss(32'h0000_8F08, 1'b1, 6'h3C, 20'h00008, base_blk(64'h700), 10);
      serve_req(0);
      for (int i = 0; i < 8; i++) beat(64'h700 + 64'(i));
      repeat (3) tick();

      chk("exp_q_drained", exp_q.size(), 0);
      chk("req_q_drained", req_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
